// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports and a per-register busy scoreboard.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates commit on the rising clk_i edge.
// Backpressure: none. Every write, reserve and read is accepted in the cycle it is presented.
//
// Ports:
//   clk_i, rst_i                   clock; asynchronous active-high reset
//   rd_addr_i / rd_data_o          NRD packed read ports (port k at [k*W +: W])
//   rd_busy_o                      per-port "operand has an outstanding W1 write"
//   w0_en_i/w0_addr_i/w0_data_i    write port 0 (ALU / writeback)
//   w1_en_i/w1_addr_i/w1_data_i    write port 1 (long-latency load return); also clears busy
//   rsv_en_i/rsv_addr_i            mark a register busy (pending W1 write)
//   wr_conflict_o                  registered pulse: previous cycle had W0 and W1 to the same nonzero address
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic                  w0_en_i,
    input  logic [ADDR_W-1:0]     w0_addr_i,
    input  logic [DATA_W-1:0]     w0_data_i,
    input  logic                  w1_en_i,
    input  logic [ADDR_W-1:0]     w1_addr_i,
    input  logic [DATA_W-1:0]     w1_data_i,
    input  logic                  rsv_en_i,
    input  logic [ADDR_W-1:0]     rsv_addr_i,
    output logic                  wr_conflict_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_conflict;

    logic w_w0_ok;
    logic w_w1_ok;
    logic w_same;

    // Writes to register 0 are discarded, so qualify both enables with a nonzero address.
    assign w_w0_ok = w0_en_i && (w0_addr_i != '0);
    assign w_w1_ok = w1_en_i && (w1_addr_i != '0);
    assign w_same  = w_w0_ok && w_w1_ok && (w0_addr_i == w1_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            // W0 wins a same-address collision: W1 data is dropped.
            if (w_w1_ok && !w_same) begin
                r_mem[w1_addr_i] <= w1_data_i;
            end
            if (w_w0_ok) begin
                r_mem[w0_addr_i] <= w0_data_i;
            end
            // Clear first, then set: a reserve in the same cycle as a W1 return to the
            // same register is a new pending write and must leave busy set.
            if (w1_en_i) begin
                r_busy[w1_addr_i] <= 1'b0;
            end
            if (rsv_en_i) begin
                r_busy[rsv_addr_i] <= 1'b1;
            end
            r_busy[0]  <= 1'b0;
            r_conflict <= w_same;
        end
    end

    assign wr_conflict_o = r_conflict;

    genvar gk;
    generate
        for (gk = 0; gk < NRD; gk++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr = rd_addr_i[gk*ADDR_W +: ADDR_W];

            always_comb begin
                w_data = r_mem[w_addr];
                w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
                if (w_w1_ok && (w1_addr_i == w_addr)) begin
                    w_data = w1_data_i;
                    w_busy = rsv_en_i && (rsv_addr_i == w_addr);
                end
                // W0 overrides W1 data, matching the storage priority.
                if (w_w0_ok && (w0_addr_i == w_addr)) begin
                    w_data = w0_data_i;
                end
`endif
                if (w_addr == '0) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rd_data_o[gk*DATA_W +: DATA_W] = w_data;
            assign rd_busy_o[gk]                  = w_busy;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed bench for regfile_mp (NRD=4) against a behavioural model.
// Latency: model compared against DUT outputs on every falling clock edge.
// Backpressure: not applicable.
module tb_regfile_mp;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]  rd_busy;
    logic            w0_en, w1_en, rsv_en;
    logic [AW-1:0]   w0_addr, w1_addr, rsv_addr;
    logic [DW-1:0]   w0_data, w1_data;
    logic            wr_conflict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .w0_en_i      (w0_en),
        .w0_addr_i    (w0_addr),
        .w0_data_i    (w0_data),
        .w1_en_i      (w1_en),
        .w1_addr_i    (w1_addr),
        .w1_data_i    (w1_data),
        .rsv_en_i     (rsv_en),
        .rsv_addr_i   (rsv_addr),
        .wr_conflict_o(wr_conflict)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem  [32];
    logic          m_busy [32];
    logic          m_conf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            m_conf = w0_en && w1_en && (w0_addr == w1_addr) && (w0_addr != 0);
            if (w1_en && w1_addr != 0) begin
                if (!(w0_en && w0_addr == w1_addr)) m_mem[w1_addr] = w1_data;
                m_busy[w1_addr] = 1'b0;
            end
            if (w0_en && w0_addr != 0) m_mem[w0_addr] = w0_data;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
    end

    function automatic logic [DW:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          b;
        if (a == 0) return '0;
        d = m_mem[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (w0_en && w0_addr == a)      d = w0_data;
        else if (w1_en && w1_addr == a) d = w1_data;
        if (w1_en && w1_addr == a)      b = rsv_en && (rsv_addr == a);
`endif
        return {b, d};
    endfunction

    // Compare process: every falling edge, all ports plus the conflict pulse.
    always @(negedge clk) begin
        for (int k = 0; k < NRD; k++) begin
            logic [DW:0] e;
            e = model_read(rd_addr[k*AW +: AW]);
            chk($sformatf("cyc_rd_data%0d", k), rd_data[k*DW +: DW], e[DW-1:0]);
            chk($sformatf("cyc_rd_busy%0d", k), {31'd0, rd_busy[k]}, {31'd0, e[DW]});
        end
        chk("cyc_conflict", {31'd0, wr_conflict}, {31'd0, m_conf});
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        w0_en = 0; w1_en = 0; rsv_en = 0;
        w0_addr = 0; w1_addr = 0; rsv_addr = 0;
        w0_data = 0; w1_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] port_data(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        #3;
        chk("reset_data0", port_data(0), 32'h0);
        chk("reset_busy", {28'd0, rd_busy}, 32'h0);
        chk("reset_conflict", {31'd0, wr_conflict}, 32'h0);
        step();
        rst = 1'b0;

        // Fill r1..r31, reserve r3.
        for (int n = 1; n < 32; n++) begin
            w0_en = 1; w0_addr = AW'(n); w0_data = 32'hA5A5_0000 + n;
            step();
        end
        idle();
        rsv_en = 1; rsv_addr = 3;
        step();
        idle();
        set_rd(0, 31); set_rd(1, 1); set_rd(2, 3); set_rd(3, 0);
        #1;
        chk("fill_r31", port_data(0), 32'hA5A5_001F);
        chk("fill_r1", port_data(1), 32'hA5A5_0001);
        chk("rsv_r3_busy", {31'd0, rd_busy[2]}, 32'd1);

        // Mid-run reset pulse between edges.
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_r31", port_data(0), 32'h0);
        chk("midrst_r3", port_data(2), 32'h0);
        chk("midrst_busy", {28'd0, rd_busy}, 32'h0);
        chk("midrst_conflict", {31'd0, wr_conflict}, 32'h0);
        step();
        rst = 1'b0;

        // Register 0 protection.
        w0_en = 1; w0_addr = 0; w0_data = 32'hDEADBEEF;
        rsv_en = 1; rsv_addr = 0;
        step();
        idle();
        for (int k = 0; k < NRD; k++) set_rd(k, 0);
        #1;
        chk("r0_data", port_data(1), 32'h0);
        chk("r0_busy", {28'd0, rd_busy}, 32'h0);

        // Write collision.
        rsv_en = 1; rsv_addr = 5;
        step();
        idle();
        w0_en = 1; w0_addr = 5; w0_data = 32'h11;
        w1_en = 1; w1_addr = 5; w1_data = 32'h22;
        step();
        idle();
        set_rd(0, 5);
        #1;
        chk("coll_data", port_data(0), 32'h11);
        chk("coll_busy", {31'd0, rd_busy[0]}, 32'd0);
        chk("coll_pulse", {31'd0, wr_conflict}, 32'd1);
        step();
        chk("coll_pulse_end", {31'd0, wr_conflict}, 32'd0);

        // Scoreboard race: reserve wins over a same-cycle W1 clear.
        rsv_en = 1; rsv_addr = 7;
        w1_en = 1; w1_addr = 7; w1_data = 32'h33;
        step();
        idle();
        set_rd(1, 7);
        #1;
        chk("race_data", port_data(1), 32'h33);
        chk("race_busy", {31'd0, rd_busy[1]}, 32'd1);
        w1_en = 1; w1_addr = 7; w1_data = 32'h34;
        step();
        idle();
        #1;
        chk("race_clear", {31'd0, rd_busy[1]}, 32'd0);

        // Bypass / no-bypass on a W1 return to a busy register.
        rsv_en = 1; rsv_addr = 9;
        step();
        idle();
        set_rd(2, 9);
        w1_en = 1; w1_addr = 9; w1_data = 32'h44;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", port_data(2), 32'h44);
        chk("byp_busy", {31'd0, rd_busy[2]}, 32'd0);
`else
        chk("nobyp_data", port_data(2), 32'h0);
        chk("nobyp_busy", {31'd0, rd_busy[2]}, 32'd1);
`endif
        step();
        idle();
        #1;
        chk("w1_next_data", port_data(2), 32'h44);
        chk("w1_next_busy", {31'd0, rd_busy[2]}, 32'd0);

        // Independent multi-port reads.
        w0_en = 1; w0_addr = 1; w0_data = 32'h10;
        w1_en = 1; w1_addr = 2; w1_data = 32'h20;
        step();
        idle();
        set_rd(0, 1); set_rd(1, 2); set_rd(2, 1); set_rd(3, 0);
        w0_en = 1; w0_addr = 2; w0_data = 32'h55;
        #1;
        chk("mp_p0", port_data(0), 32'h10);
`ifdef REGFILE_BYPASS_EN
        chk("mp_p1", port_data(1), 32'h55);
`else
        chk("mp_p1", port_data(1), 32'h20);
`endif
        chk("mp_p2", port_data(2), 32'h10);
        chk("mp_p3", port_data(3), 32'h0);
        step();
        idle();
        #1;
        chk("mp_p1_next", port_data(1), 32'h55);

        // Randomized traffic, narrow address range to force collisions and races.
        for (int c = 0; c < 3000; c++) begin
            w0_en    = ($urandom_range(0, 2) != 0);
            w0_addr  = AW'($urandom_range(0, 7));
            w0_data  = $urandom;
            w1_en    = ($urandom_range(0, 2) == 0);
            w1_addr  = AW'($urandom_range(0, 7));
            w1_data  = $urandom;
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            for (int k = 0; k < NRD; k++) begin
                set_rd(k, AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)));
            end
            if ($urandom_range(0, 399) == 0) begin
                #1;
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        idle();
        step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
